traffic_phase_timer: RTL

Phase timer that sits directly upstream of the three-colour intersection light controller. It divides the system clock into one-second ticks, times each traffic phase (north-south go, north-south clear, east-west go, east-west clear) and emits a one-cycle `advance` pulse at every phase boundary; the downstream controller steps its state on that pulse. A latched pedestrian request shortens the current go phase once its minimum green time has elapsed.

---
 rtl/traffic_phase_timer.sv | 100 ++++++++++
 1 files changed

// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: divides clk into one-second ticks, times the four
// intersection phases and pulses `advance` for one cycle at each phase
// boundary. A latched pedestrian request may end a go phase early once the
// minimum green time has elapsed.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   enable   in   1 = timing runs, 0 = prescaler and phase timing frozen
//   ped_req  in   pedestrian request, sampled every rising edge
//   advance  out  one-cycle pulse, phase boundary just taken
//   phase    out  0 NS_GO, 1 NS_CLEAR, 2 EW_GO, 3 EW_CLEAR
//   ped_wait out  pedestrian request latched and not yet served
module traffic_phase_timer #(
    parameter int unsigned PRESCALE      = 50_000_000,
    parameter int unsigned GREEN_SEC     = 20,
    parameter int unsigned YELLOW_SEC    = 4,
    parameter int unsigned MIN_GREEN_SEC = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       ped_req,
    output logic       advance,
    output logic [1:0] phase,
    output logic       ped_wait
);

    localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        NS_GO    = 2'd0,
        NS_CLEAR = 2'd1,
        EW_GO    = 2'd2,
        EW_CLEAR = 2'd3
    } phase_t;

    phase_t        state;
    logic [PW-1:0] pre_cnt;
    logic [7:0]    elapsed;

    logic          tick;
    logic          go_phase;
    logic [8:0]    elapsed_next;   // one extra bit so elapsed=255 cannot wrap
    logic          normal_end;
    logic          early_end;
    logic          phase_end;

    // End-of-phase detection, evaluated against the tick about to be counted
    assign tick         = enable && (pre_cnt == PW'(PRESCALE - 1));
    assign go_phase     = ~state[0];
    assign elapsed_next = {1'b0, elapsed} + 9'd1;
    assign normal_end   = elapsed_next == (go_phase ? 9'(GREEN_SEC) : 9'(YELLOW_SEC));
    assign early_end    = go_phase && ped_wait && (elapsed_next >= 9'(MIN_GREEN_SEC));
    assign phase_end    = tick && (normal_end || early_end);

    assign phase = state;

    // Prescaler, elapsed counter, phase FSM and pedestrian latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= NS_GO;
            pre_cnt  <= '0;
            elapsed  <= '0;
            advance  <= 1'b0;
            ped_wait <= 1'b0;
        end else begin
            advance <= 1'b0;

            // Prescaler free-runs across phase changes
            if (enable) begin
                pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
            end

            if (tick) begin
                if (phase_end) begin
                    elapsed <= '0;
                    advance <= 1'b1;
                    case (state)
                        NS_GO:    state <= NS_CLEAR;
                        NS_CLEAR: state <= EW_GO;
                        EW_GO:    state <= EW_CLEAR;
                        EW_CLEAR: state <= NS_GO;
                        default:  state <= NS_GO;
                    endcase
                end else begin
                    elapsed <= elapsed + 8'd1;
                end
            end

            // A request on the same edge as entering a clear phase stays latched
            if (ped_req) begin
                ped_wait <= 1'b1;
            end else if (phase_end && go_phase) begin
                ped_wait <= 1'b0;
            end
        end
    end

endmodule
